execution_unit_pipe: RTL
========================

EXECUTION_UNIT_PIPE -- requirements
Module: execution_unit_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, lane width in bits.
REQ-002 SHALL have parameter LANES, default 16, vector lane count (>=1).
REQ-003 SHALL have parameter FRAC_BITS, default 8, fixed-point fraction bits (<DATA_WIDTH).
REQ-004 SHALL have parameter MUL_CYCLES, default 3, multiply latency in cycles (>=1).
REQ-005 SHALL have one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock.
REQ-006 SHALL have rst input 1, asynchronous active-high reset.
REQ-007 SHALL have in_valid input 1 and in_ready output 1, the operation-accept handshake.
REQ-008 SHALL have opcode input 5: [4:3] class (00 int, 01 fixed, 10 vector), [2:0] op (000 ADD, 001 SUB, 010 MUL).
REQ-009 SHALL have s_mux_A and s_mux_B inputs 1, operand source select (0 decode, 1 forwarded).
REQ-010 SHALL have A_deco, B_deco, A_ua and B_ua inputs LANES*DATA_WIDTH, packed operands with lane i at [i*DW+:DW].
REQ-011 SHALL have out_valid output 1 and out_ready input 1, the result handshake.
REQ-012 SHALL have out_data output LANES*DATA_WIDTH for results, out_class output 2 echoing the accepted class, and out_err output 1 flagging an illegal opcode.
REQ-013 SHALL have C, N, V and Z outputs, LANES bits each, per-lane flags.

Function
REQ-014 Accept SHALL occur on in_valid&&in_ready; the muxed operands and opcode SHALL be registered at accept.
REQ-015 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready).
REQ-016 The FSM SHALL have states IDLE, BUSY, DONE; an ADD, SUB or illegal op SHALL go IDLE->DONE; a MUL SHALL go IDLE->BUSY if MUL_CYCLES>1, else to DONE.
REQ-017 BUSY SHALL load a counter with MUL_CYCLES-1 at accept, decrement each cycle, and enter DONE when it reaches 1.
REQ-018 out_valid SHALL be high exactly in DONE; out_data, flags, out_class and out_err SHALL stay stable until out_ready.
REQ-019 DONE with out_ready and no accept SHALL go to IDLE; DONE with out_ready and an accept SHALL start the new op in the same cycle (back-to-back, no bubble).
REQ-020 Latency from accept to out_valid SHALL be 1 cycle for ADD/SUB and MUL_CYCLES cycles for MUL.
REQ-021 For classes int and fixed only lane 0 SHALL compute; all other lanes of out_data and of the flags SHALL be 0.
REQ-022 For vector class all LANES SHALL compute independently as signed int.
REQ-023 ADD/SUB SHALL produce A+B and A-B modulo 2^DW.
REQ-024 Int MUL SHALL produce the low DW bits of the 2DW signed product.
REQ-025 Fixed MUL SHALL produce product >>> FRAC_BITS (arithmetic shift), low DW bits.
REQ-026 C SHALL be the carry-out of A+B or of A+~B+1, and 0 for MUL.
REQ-027 V SHALL be signed overflow for ADD/SUB; for MUL, V SHALL be set when the discarded upper bits are not the sign extension of the result.
REQ-028 N SHALL be the result MSB and Z SHALL be (result==0).
REQ-029 An illegal class or op SHALL be accepted, SHALL yield zero data and flags with out_err=1, and SHALL take 1 cycle.

Reset
REQ-030 rst SHALL force IDLE, counter 0, out_valid 0, and out_data, flags, out_class and out_err to 0 immediately.
REQ-031 A reset mid-BUSY or mid-DONE SHALL discard the in-flight op with no output.
REQ-032 in_ready SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-033 With SATURATE_EN defined, fixed-class and vector-class results SHALL clamp to 2^(DW-1)-1 or -2^(DW-1) when V=1, V SHALL remain set, and int-class results SHALL still wrap.
REQ-034 Without SATURATE_EN, all classes SHALL wrap as in REQ-023..025.

Verification (DW=16, LANES=4, FRAC=8, MUL_CYCLES=3)
REQ-035 Int ADD 0x7FFF+0x0001 -> out_valid 1 cycle later, data 0x8000, V=1, N=1, C=0, Z=0, lanes 1-3 zero.
REQ-036 Fixed MUL 0x0180*0x0200 (1.5*2.0) -> out_valid 3 cycles after accept, data 0x0300, V=0.
REQ-037 Vector SUB lanes {5,0,-1,0x8000} minus {5,1,-1,1} -> data {0,0xFFFF,0,0x7FFF}, Z={1,0,1,0}, V lane3=1 (0x7FFF with SATURATE_EN=0x8000 clamp -> 0x8000).
REQ-038 out_ready held low for 4 cycles -> out_valid and data stable, in_ready 0; then out_ready=1 with in_valid=1 -> new op accepted the same cycle.
REQ-039 rst asserted in cycle 2 of a MUL -> out_valid stays 0 and all outputs read 0 at once; after release, in_ready=1.
REQ-040 opcode 5'b11000 -> out_err=1, data 0, 1-cycle latency; s_mux_A=1 selects A_ua, verified by ADD A_ua=3, A_deco=9, B=1 -> 4.

Source files
------------

// File: rtl/execution_unit_pipe.sv
// Multi-class execution unit: int/fixed scalar and vector ADD/SUB/MUL with a
// one-op-in-flight handshake. Optional result saturation under `SATURATE_EN.
module execution_unit_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16,
    parameter int FRAC_BITS  = 8,
    parameter int MUL_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4:0]                  opcode,
    input  logic                        s_mux_A,
    input  logic                        s_mux_B,
    input  logic [LANES*DATA_WIDTH-1:0] A_deco,
    input  logic [LANES*DATA_WIDTH-1:0] B_deco,
    input  logic [LANES*DATA_WIDTH-1:0] A_ua,
    input  logic [LANES*DATA_WIDTH-1:0] B_ua,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [1:0]                  out_class,
    output logic                        out_err,
    output logic [LANES-1:0]            C,
    output logic [LANES-1:0]            N,
    output logic [LANES-1:0]            V,
    output logic [LANES-1:0]            Z
);

    localparam logic [1:0] CLS_INT = 2'b00;
    localparam logic [1:0] CLS_FIX = 2'b01;
    localparam logic [1:0] CLS_VEC = 2'b10;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam int         CNT_W   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] res;
        logic                  c;
        logic                  n;
        logic                  v;
        logic                  z;
    } lane_t;

    // One lane of arithmetic; flags come from the final (possibly clamped) result.
    function automatic lane_t calc_lane(input logic signed [DATA_WIDTH-1:0] a,
                                        input logic signed [DATA_WIDTH-1:0] b,
                                        input logic [1:0] cls,
                                        input logic [2:0] op);
        lane_t                          l;
        logic [DATA_WIDTH:0]            sum;
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [2*DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0]          r;
        logic                           c;
        logic                           v;
`ifdef SATURATE_EN
        logic                           neg;
`endif
        sum  = '0;
        prod = '0;
        sh   = '0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[DATA_WIDTH-1:0];
                c   = sum[DATA_WIDTH];
                v   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};
                r   = sum[DATA_WIDTH-1:0];
                c   = sum[DATA_WIDTH];
                v   = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (r[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            default: begin
                prod = a * b;
                sh   = (cls == CLS_FIX) ? (prod >>> FRAC_BITS) : prod;
                r    = sh[DATA_WIDTH-1:0];
                v    = (sh[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{r[DATA_WIDTH-1]}});
            end
        endcase
`ifdef SATURATE_EN
        // The true sign of an overflowed sum is the inverse of the wrapped MSB.
        neg = (op == OP_MUL) ? sh[2*DATA_WIDTH-1] : ~r[DATA_WIDTH-1];
        if (v && cls != CLS_INT)
            r = neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`endif
        l.res = r;
        l.c   = c;
        l.n   = r[DATA_WIDTH-1];
        l.v   = v;
        l.z   = (r == '0);
        return l;
    endfunction

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    accept;
    logic                    legal;
    logic [LANES*DATA_WIDTH-1:0] a_p0, b_p0;
    logic [1:0]              cls_p0;
    logic [2:0]              op_p0;
    logic                    err_p0;
    logic [LANES*DATA_WIDTH-1:0] data_c;
    logic [LANES-1:0]        c_c, n_c, v_c, z_c;
    lane_t                   lr;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign legal    = (opcode[4:3] != 2'b11) && (opcode[2:0] <= OP_MUL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            BUSY: begin
                if (cnt == CNT_W'(1))
                    state_n = DONE;
                else
                    cnt_n = cnt - 1'b1;
            end
            default: begin
                if (state == DONE && out_ready)
                    state_n = IDLE;
                if (accept) begin
                    if (legal && opcode[2:0] == OP_MUL && MUL_CYCLES > 1) begin
                        state_n = BUSY;
                        cnt_n   = CNT_W'(MUL_CYCLES - 1);
                    end else begin
                        state_n = DONE;
                    end
                end
            end
        endcase
    end

    // Stage p0: operands and opcode captured at accept; held until the next accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0   <= s_mux_A ? A_ua : A_deco;
            b_p0   <= s_mux_B ? B_ua : B_deco;
            cls_p0 <= opcode[4:3];
            op_p0  <= opcode[2:0];
            err_p0 <= !legal;
        end
    end

    // Results are only exposed in DONE, so reset zeroes every output at once.
    always_comb begin
        data_c = '0;
        c_c    = '0;
        n_c    = '0;
        v_c    = '0;
        z_c    = '0;
        lr     = '0;
        if (state == DONE && !err_p0) begin
            for (int i = 0; i < LANES; i++) begin
                if (i == 0 || cls_p0 == CLS_VEC) begin
                    lr = calc_lane(a_p0[i*DATA_WIDTH +: DATA_WIDTH],
                                   b_p0[i*DATA_WIDTH +: DATA_WIDTH], cls_p0, op_p0);
                    data_c[i*DATA_WIDTH +: DATA_WIDTH] = lr.res;
                    c_c[i] = lr.c;
                    n_c[i] = lr.n;
                    v_c[i] = lr.v;
                    z_c[i] = lr.z;
                end
            end
        end
    end

    assign out_valid = (state == DONE);
    assign out_data  = data_c;
    assign out_class = (state == DONE) ? cls_p0 : 2'b00;
    assign out_err   = (state == DONE) && err_p0;
    assign C         = c_c;
    assign N         = n_c;
    assign V         = v_c;
    assign Z         = z_c;

endmodule
